// File: rtl/la_serial_frame_rx.sv
// Purpose : UART-style frame receiver for the logic-analyzer output path.
//           Frame format: start, DATA_W data bits LSB first, even parity, stop.
// Latency : 2-cycle input synchronizer. data_valid_o rises 1 cycle after the
//           mid-stop-bit sample edge.
// Backpr. : none. The serial line cannot be stalled. data_o holds the last good
//           word until a newer good frame replaces it.
//
// Ports:
//   wb_clk_i      sole clock
//   wb_rst_ni     synchronous active-low reset
//   serial_i      asynchronous serial line, idle high
//   err_clr_i     level; clears both sticky error flags (a set in the same cycle wins)
//   data_o        last frame received without error
//   data_valid_o  one-cycle pulse when data_o updates
//   frame_cnt_o   good-frame counter, wraps
//   parity_err_o  sticky parity error
//   framing_err_o sticky framing error (stop bit low)
//   busy_o        FSM not in IDLE
module la_serial_frame_rx #(
  parameter int DATA_W       = 32,
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              serial_i,
  input  logic              err_clr_i,
  output logic [DATA_W-1:0] data_o,
  output logic              data_valid_o,
  output logic [CNT_W-1:0]  frame_cnt_o,
  output logic              parity_err_o,
  output logic              framing_err_o,
  output logic              busy_o
);

  localparam int TICK_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t             state, state_n;
  logic [TICK_W-1:0]  tick_cnt, tick_n;
  logic [BIT_W-1:0]   bit_cnt, bit_n;

  logic               rx_meta, rx_s;
  logic [DATA_W-1:0]  shift_q;
  logic [DATA_W:0]    shift_ext;
  logic               parity_ok;

  // Strobes from the FSM to the datapath.
  logic               shift_en, parity_en, stop_en;

  // New bit enters at the MSB end so the first bit received ends up at bit 0.
  // Going through a DATA_W+1 wide vector keeps this legal for DATA_W == 1.
  assign shift_ext = {rx_s, shift_q};

  assign busy_o = (state != IDLE);

  // State register and bit/tick counters.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_n;
      bit_cnt  <= bit_n;
    end
  end

  // Next-state logic. Every sample point also restarts the tick counter so that
  // the next sample falls one full bit period later, at mid-bit.
  always_comb begin
    state_n   = state;
    tick_n    = tick_cnt + TICK_W'(1);
    bit_n     = bit_cnt;
    shift_en  = 1'b0;
    parity_en = 1'b0;
    stop_en   = 1'b0;
    case (state)
      IDLE: begin
        tick_n = '0;
        bit_n  = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (tick_cnt == TICK_HALF) begin
          tick_n  = '0;
          bit_n   = '0;
          // A line that is already high again at mid start bit was a glitch.
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick_cnt == TICK_LAST) begin
          tick_n   = '0;
          shift_en = 1'b1;
          bit_n    = bit_cnt + BIT_W'(1);
          if (bit_cnt == BIT_LAST) begin
            bit_n   = '0;
            state_n = PARITY;
          end
        end
      end
      PARITY: begin
        if (tick_cnt == TICK_LAST) begin
          tick_n    = '0;
          parity_en = 1'b1;
          state_n   = STOP;
        end
      end
      STOP: begin
        if (tick_cnt == TICK_LAST) begin
          tick_n  = '0;
          stop_en = 1'b1;
          // A low stop bit may be the start of a break; wait it out so a long
          // low line only produces one framing error.
          state_n = rx_s ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        tick_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        tick_n  = '0;
        bit_n   = '0;
      end
    endcase
  end

  // Synchronizer, shift register, result registers and sticky flags.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      rx_meta       <= 1'b1;
      rx_s          <= 1'b1;
      shift_q       <= '0;
      parity_ok     <= 1'b0;
      data_o        <= '0;
      data_valid_o  <= 1'b0;
      frame_cnt_o   <= '0;
      parity_err_o  <= 1'b0;
      framing_err_o <= 1'b0;
    end else begin
      rx_meta      <= serial_i;
      rx_s         <= rx_meta;
      data_valid_o <= 1'b0;

      // Clear first; the set below overrides it when both happen in one cycle.
      if (err_clr_i) begin
        parity_err_o  <= 1'b0;
        framing_err_o <= 1'b0;
      end

      if (shift_en) shift_q <= shift_ext[DATA_W:1];

      // Even parity: data bits plus parity bit must XOR to zero.
      if (parity_en) parity_ok <= ~(^shift_ext);

      if (stop_en) begin
        if (rx_s) begin
          if (parity_ok) begin
            data_o       <= shift_q;
            data_valid_o <= 1'b1;
            frame_cnt_o  <= frame_cnt_o + CNT_W'(1);
          end else begin
            parity_err_o <= 1'b1;
          end
        end else begin
          framing_err_o <= 1'b1;
        end
      end
    end
  end

endmodule
